// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmitter and receiver.
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;

    localparam int FRAME_BITS         = 10;
    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_TIMEOUT_CYCLES = 750000;
    localparam int DEF_SYNC_STAGES    = 2;

    // Data bits LSB first, then odd parity, then the stop bit.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronises the PS/2 clock/data pins and flags clock falling edges.
module ps2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_s,
    output logic dat_s,
    output logic fe
);

    logic [STAGES-1:0] clk_q;
    logic [STAGES-1:0] dat_q;
    logic              clk_d;

    // Reset to the idle (released, pulled-up) line level so no spurious edge follows reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_q <= '1;
            dat_q <= '1;
            clk_d <= 1'b1;
        end else begin
            clk_q <= {clk_q[STAGES-2:0], clk_in};
            dat_q <= {dat_q[STAGES-2:0], dat_in};
            clk_d <= clk_q[STAGES-1];
        end
    end

    assign clk_s = clk_q[STAGES-1];
    assign dat_s = dat_q[STAGES-1];
    assign fe    = clk_d & ~clk_s;

endmodule

// File: rtl/ps2_transmit.sv
// ps2_transmit: PS/2 host-to-device byte transmitter driving open-drain clock/data enables.
module ps2_transmit
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state;
    logic [FRAME_BITS-1:0]   shift;
    logic [3:0]              bitcnt;
    logic [IW-1:0]           cnt;
    logic [TW-1:0]           timeout;
    logic                    clk_s;
    logic                    dat_s;
    logic                    fe;

    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clock  (clock),
        .reset  (reset),
        .clk_in (ps2_clk_in),
        .dat_in (ps2_dat_in),
        .clk_s  (clk_s),
        .dat_s  (dat_s),
        .fe     (fe)
    );

    assign rx_inhibit = busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            shift      <= '0;
            bitcnt     <= '0;
            cnt        <= '0;
            timeout    <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: if (tx_valid) begin
                    shift      <= make_frame(tx_data);
                    ps2_clk_oe <= 1'b1;
                    cnt        <= IW'(INHIBIT_CYCLES - 1);
                    state      <= INHIBIT;
                    tx_ready   <= 1'b0;
                    busy       <= 1'b1;
                end
                INHIBIT: if (cnt == '0) begin
                    ps2_dat_oe <= 1'b1;
                    state      <= RTS;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RTS: begin
                    ps2_clk_oe <= 1'b0;
                    timeout    <= TW'(TIMEOUT_CYCLES - 1);
                    bitcnt     <= '0;
                    state      <= SHIFT;
                end
                default: if (timeout == '0) begin
                    // The device stalled somewhere in the frame: abandon it.
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    error      <= 1'b1;
                    state      <= IDLE;
                    tx_ready   <= 1'b1;
                    busy       <= 1'b0;
                end else begin
                    timeout <= timeout - 1'b1;
                    case (state)
                        SHIFT: if (fe) begin
                            ps2_dat_oe <= ~shift[0];
                            shift      <= shift >> 1;
                            bitcnt     <= bitcnt + 1'b1;
                            if (bitcnt == 4'(FRAME_BITS - 1))
                                state <= ACK;
                        end
                        ACK: if (fe) begin
                            if (!dat_s) begin
                                state <= WAIT_IDLE;
                            end else begin
                                ps2_clk_oe <= 1'b0;
                                ps2_dat_oe <= 1'b0;
                                error      <= 1'b1;
                                state      <= IDLE;
                                tx_ready   <= 1'b1;
                                busy       <= 1'b0;
                            end
                        end
                        default: if (clk_s && dat_s) begin
                            done     <= 1'b1;
                            state    <= IDLE;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule
